// File: rtl/tetris_pkg.sv
// Shared board defaults, row type and collapse FSM state encoding for the
// line-clear engine and its board owner.
package tetris_pkg;

  localparam int ROW_W_DEF = 12;
  localparam int ROWS_DEF  = 22;

  typedef logic [ROW_W_DEF-1:0] row_t;

  // Walls set, playfield clear.
  localparam row_t FILL_ROW_DEF = 12'h801;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/line_clear_engine_if.sv
// Board read/write port between the line-clear engine (master) and the
// board storage owner (slave). rd_data answers rd_addr in the same cycle.
interface line_clear_engine_if #(
  parameter int ROWS  = 22,
  parameter int ROW_W = 12
);
  localparam int AW = $clog2(ROWS);

  logic [AW-1:0]    rd_addr;
  logic [ROW_W-1:0] rd_data;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [ROW_W-1:0] wr_data;

  modport master (
    output rd_addr,
    output wr_en,
    output wr_addr,
    output wr_data,
    input  rd_data
  );

  modport slave (
    input  rd_addr,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output rd_data
  );

endinterface

// File: rtl/line_clear_engine_row_full_detect.sv
// Flags a board row whose playfield columns COL_LO..COL_HI are all occupied;
// wall bits outside that range never affect the result.
module row_full_detect #(
  parameter int ROW_W  = 12,
  parameter int COL_LO = 1,
  parameter int COL_HI = 10
) (
  input  logic [ROW_W-1:0] row,
  output logic             full
);

  assign full = &row[COL_HI:COL_LO];

endmodule

// File: rtl/line_clear_engine.sv
// Scans the board bottom-up, compacts surviving rows downward in one pass and
// refills the vacated top rows with FILL_ROW.
module line_clear_engine
  import tetris_pkg::*;
#(
  parameter int               ROW_W    = ROW_W_DEF,
  parameter int               COL_LO   = 1,
  parameter int               COL_HI   = 10,
  parameter int               ROWS     = ROWS_DEF,
  parameter logic [ROW_W-1:0] FILL_ROW = ROW_W'(FILL_ROW_DEF)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  line_clear_engine_if.master        bus,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(ROWS+1)-1:0]  lines_cleared,
  output logic [ROWS-1:0]            cleared_mask
);

  localparam int AW = $clog2(ROWS);
  localparam int CW = $clog2(ROWS+1);

  state_t           state_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    scan_cnt_r;
  logic [CW-1:0]    count_r;
  logic [ROWS-1:0]  mask_r;
  logic             busy_r;
  logic             done_r;
  logic             full_s;
  logic             last_scan_s;
  logic             wr_en_s;
  logic [AW-1:0]    wr_addr_s;
  logic [ROW_W-1:0] wr_data_s;

  row_full_detect #(
    .ROW_W  (ROW_W),
    .COL_LO (COL_LO),
    .COL_HI (COL_HI)
  ) u_row_full_detect (
    .row  (bus.rd_data),
    .full (full_s)
  );

  assign last_scan_s = (scan_cnt_r == AW'(ROWS-1));

  // Collapse FSM: pointers, scan counter, clear statistics and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      scan_cnt_r <= '0;
      count_r    <= '0;
      mask_r     <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r    <= SCAN;
            rd_ptr_r   <= AW'(ROWS-1);
            wr_ptr_r   <= AW'(ROWS-1);
            scan_cnt_r <= '0;
            count_r    <= '0;
            mask_r     <= '0;
            busy_r     <= 1'b1;
          end
        end
        SCAN: begin
          if (full_s) begin
            count_r          <= count_r + CW'(1);
            mask_r[rd_ptr_r] <= 1'b1;
          end else if (wr_ptr_r != '0) begin
            wr_ptr_r <= wr_ptr_r - AW'(1);
          end
          // Pointers saturate at row 0; termination comes from scan_cnt_r.
          if (rd_ptr_r != '0) begin
            rd_ptr_r <= rd_ptr_r - AW'(1);
          end
          scan_cnt_r <= scan_cnt_r + AW'(1);
          if (last_scan_s) begin
            state_r <= ((count_r != '0) || full_s) ? FILL : DONE;
          end
        end
        FILL: begin
          if (wr_ptr_r == '0) begin
            state_r <= DONE;
          end else begin
            wr_ptr_r <= wr_ptr_r - AW'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Write port is combinational: rows move in the same cycle they are read.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = '0;
    wr_data_s = '0;
    case (state_r)
      SCAN: begin
        wr_data_s = bus.rd_data;
        if (!full_s && (wr_ptr_r != rd_ptr_r)) begin
          wr_en_s   = 1'b1;
          wr_addr_s = wr_ptr_r;
        end else begin
          wr_en_s   = 1'b0;
          wr_addr_s = '0;
        end
      end
      FILL: begin
        wr_en_s   = 1'b1;
        wr_addr_s = wr_ptr_r;
        wr_data_s = FILL_ROW;
      end
      default: begin
        wr_en_s   = 1'b0;
        wr_addr_s = '0;
        wr_data_s = '0;
      end
    endcase
  end

  assign bus.rd_addr   = rd_ptr_r;
  assign bus.wr_en     = wr_en_s;
  assign bus.wr_addr   = wr_addr_s;
  assign bus.wr_data   = wr_data_s;
  assign busy          = busy_r;
  assign done          = done_r;
  assign lines_cleared = count_r;
  assign cleared_mask  = mask_r;

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine: a queue-based model of the collapse
// predicts the final board, counts, write total and per-cycle busy/done/wr_en.
module tb_line_clear_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic        busy_a, done_a, busy_b, done_b;
  logic [4:0]  lc_a;
  logic [21:0] mask_a;
  logic [3:0]  lc_b;
  logic [7:0]  mask_b;
  logic        load_a, load_b;
  logic [11:0] board_a [22];
  logic [11:0] pat_a   [22];
  logic [7:0]  board_b [8];

  int errors = 0;
  int checks = 0;
  int cyc_a = -1;
  int exp_k_a = 0;
  int writes_a = 0;
  logic [21:0] written_a = '0;

  line_clear_engine_if #(.ROWS(22), .ROW_W(12)) bus_a ();
  line_clear_engine_if #(.ROWS(8),  .ROW_W(8))  bus_b ();

  line_clear_engine dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bus(bus_a),
    .busy(busy_a), .done(done_a), .lines_cleared(lc_a), .cleared_mask(mask_a)
  );

  line_clear_engine #(
    .ROW_W(8), .COL_LO(0), .COL_HI(7), .ROWS(8), .FILL_ROW(8'h3C)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bus(bus_b),
    .busy(busy_b), .done(done_b), .lines_cleared(lc_b), .cleared_mask(mask_b)
  );

  always #5 clk = ~clk;

  assign bus_a.rd_data = board_a[bus_a.rd_addr];
  assign bus_b.rd_data = board_b[bus_b.rd_addr];

  always @(posedge clk) begin
    if (load_a) board_a <= pat_a;
    else if (bus_a.wr_en) board_a[bus_a.wr_addr] <= bus_a.wr_data;
  end

  always @(posedge clk) begin
    if (load_b) begin
      for (int i = 0; i < 8; i++) board_b[i] <= 8'hFF;
    end else if (bus_b.wr_en) begin
      board_b[bus_b.wr_addr] <= bus_b.wr_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit is_full_a(input logic [11:0] r);
    logic [11:0] pm;
    pm = ((12'd1 << 11) - 12'd1) ^ ((12'd1 << 1) - 12'd1);
    return (r & pm) == pm;
  endfunction

  // Per-cycle compare: cyc_a is edges since the accepting edge, -1 when idle.
  always @(negedge clk) begin
    if (reset) begin
      check("busy_rst", busy_a, 1'b0);
      check("wr_en_rst", bus_a.wr_en, 1'b0);
      cyc_a <= -1;
    end else begin
      check("busy", busy_a, (cyc_a >= 0) && (cyc_a <= 22 + exp_k_a));
      check("done", done_a, cyc_a == 23 + exp_k_a);
      if (cyc_a < 0 || cyc_a >= 22 + exp_k_a) check("wr_en_idle", bus_a.wr_en, 1'b0);
      if (bus_a.wr_en) begin
        check("double_write", written_a[bus_a.wr_addr], 1'b0);
        written_a[bus_a.wr_addr] <= 1'b1;
        writes_a <= writes_a + 1;
      end
      if (start_a && !busy_a) begin
        cyc_a     <= 0;
        written_a <= '0;
        writes_a  <= 0;
      end else if (cyc_a == 23 + exp_k_a) begin
        cyc_a <= -1;
      end else if (cyc_a >= 0) begin
        cyc_a <= cyc_a + 1;
      end
    end
  end

  task automatic run_a(input string tag, input bit poke, input int lit_lat, input logic [21:0] lit_mask);
    logic [11:0] q[$];
    int          qi[$];
    logic [11:0] exp_b [22];
    logic [21:0] m;
    int k, mv, n;
    bit got;
    k = 0; m = '0; mv = 0;
    for (int i = 0; i < 22; i++) begin
      if (is_full_a(pat_a[i])) begin
        k++;
        m[i] = 1'b1;
      end else begin
        q.push_back(pat_a[i]);
        qi.push_back(i);
      end
    end
    for (int i = 0; i < 22; i++) exp_b[i] = (i < k) ? 12'h801 : q[i-k];
    for (int j = 0; j < qi.size(); j++) if (qi[j] != k + j) mv++;
    check({tag, "_model_mask"}, m, lit_mask);
    check({tag, "_model_lat"}, 23 + k, lit_lat);
    exp_k_a = k;
    @(posedge clk); #1 load_a = 1'b1;
    @(posedge clk); #1 load_a = 1'b0; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 60) begin
      @(posedge clk); n++;
      #1 start_a = poke && (n == 5);
      @(negedge clk); got = done_a;
    end
    check({tag, "_done_seen"}, got, 1'b1);
    check({tag, "_latency"}, n, 23 + k);
    check({tag, "_lines"}, lc_a, k);
    check({tag, "_mask"}, mask_a, m);
    check({tag, "_writes"}, writes_a, mv + k);
    check({tag, "_row0"}, board_a[0], 12'h801);
    for (int i = 0; i < 22; i++) check($sformatf("%s_row%0d", tag, i), board_a[i], exp_b[i]);
    @(negedge clk);
    check({tag, "_lines_hold"}, lc_a, k);
    check({tag, "_done_pulse"}, done_a, 1'b0);
  endtask

  task automatic base_pattern();
    for (int i = 0; i < 22; i++) pat_a[i] = 12'h801 | (12'(i + 1) << 1);
  endtask

  initial begin
    int n;
    bit got;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; load_a = 1'b0; load_b = 1'b0;
    #12;
    check("rst_lines", lc_a, 5'd0);
    check("rst_mask", mask_a, 22'd0);
    check("rst_rd_addr", bus_a.rd_addr, 5'd0);
    check("rst_wr_addr", bus_a.wr_addr, 5'd0);
    check("rst_done", done_a, 1'b0);
    @(posedge clk); #1 reset = 1'b0;

    for (int i = 0; i < 22; i++) pat_a[i] = 12'h801;
    run_a("empty", 1'b0, 23, 22'h000000);

    base_pattern(); pat_a[21] = 12'hFFF;
    run_a("one", 1'b0, 24, 22'h200000);

    base_pattern();
    pat_a[21] = 12'hFFF; pat_a[19] = 12'h7FE; pat_a[18] = 12'hFFF; pat_a[10] = 12'h7FE;
    run_a("four", 1'b1, 27, 22'h2C0400);

    base_pattern(); pat_a[21] = 12'hFDF; pat_a[20] = 12'h7FE;
    run_a("edge", 1'b0, 24, 22'h100000);

    // Abort mid-scan while rows are being moved.
    base_pattern(); pat_a[21] = 12'hFFF; exp_k_a = 1;
    @(posedge clk); #1 load_a = 1'b1;
    @(posedge clk); #1 load_a = 1'b0; start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk); check("abort_wr_before", bus_a.wr_en, 1'b1);
    @(posedge clk); #1 reset = 1'b1;
    #1;
    check("abort_busy", busy_a, 1'b0);
    check("abort_wr_en", bus_a.wr_en, 1'b0);
    check("abort_lines", lc_a, 5'd0);
    check("abort_mask", mask_a, 22'd0);
    @(posedge clk); #1 reset = 1'b0;
    run_a("after", 1'b0, 24, 22'h200000);

    // Small board, every row full.
    @(posedge clk); #1 load_b = 1'b1;
    @(posedge clk); #1 load_b = 1'b0; start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk); got = done_b;
    end
    check("b_done_seen", got, 1'b1);
    check("b_latency", n, 17);
    check("b_lines", lc_b, 4'd8);
    check("b_mask", mask_b, 8'hFF);
    for (int i = 0; i < 8; i++) check($sformatf("b_row%0d", i), board_b[i], 8'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
